// File: rtl/i2s_transmitter.sv
// I2S serializer: takes one mono sample per frame over valid/ready and sends it in
// both the left and right slots, with bclk derived from the system clock.
module i2s_transmitter #(
   parameter int unsigned SAMPLE_WIDTH = 24,
   parameter int unsigned BCLK_DIV     = 8
) (
   input  logic                    system_clock,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    sdata,
   output logic                    frame_start,
   output logic                    underrun
);

   localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int unsigned PAD_W = 32 - SAMPLE_WIDTH;
   localparam int unsigned CNT_W = 6;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0]        div_cnt_q,     div_cnt_d;
   logic                    bclk_q,        bclk_d;
   logic [CNT_W-1:0]        bit_cnt_q,     bit_cnt_d;
   logic                    lrclk_q,       lrclk_d;
   logic                    sdata_q,       sdata_d;
   logic                    frame_start_q, frame_start_d;
   logic                    underrun_q,    underrun_d;
   logic                    hold_valid_q,  hold_valid_d;
   logic [SAMPLE_WIDTH-1:0] hold_word_q,   hold_word_d;
   logic [SAMPLE_WIDTH-1:0] frame_word_q,  frame_word_d;

   logic             div_wrap;
   logic             fall_tick;
   logic             frame_load;
   logic             accept;
   logic [CNT_W-1:0] bit_next;
   logic [32:0]      slot_word;
   logic [CNT_W-1:0] slot_sel;

   // Slot image: bit 32 is the one-bit-delay zero, the sample follows MSB first,
   // zero padding fills the rest of the 32-bit slot.
   always_comb begin
      div_cnt_d     = div_cnt_q;
      bclk_d        = bclk_q;
      bit_cnt_d     = bit_cnt_q;
      lrclk_d       = lrclk_q;
      sdata_d       = sdata_q;
      frame_start_d = 1'b0;
      underrun_d    = underrun_q;
      hold_valid_d  = hold_valid_q;
      hold_word_d   = hold_word_q;
      frame_word_d  = frame_word_q;

      div_wrap   = (div_cnt_q == DIV_LAST);
      fall_tick  = div_wrap && bclk_q;
      bit_next   = bit_cnt_q + CNT_W'(1);
      frame_load = fall_tick && (bit_cnt_q == CNT_W'(63));
      accept     = sample_valid && !hold_valid_q;
      slot_word  = {1'b0, frame_word_q, PAD_W'(0)};
      slot_sel   = CNT_W'(32) - {1'b0, bit_next[4:0]};

      div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      if (div_wrap) begin
         bclk_d = !bclk_q;
      end

      if (accept) begin
         hold_word_d  = sample_in;
         hold_valid_d = 1'b1;
      end

      // Load never bypasses: a sample accepted on this cycle waits for next frame.
      if (frame_load) begin
         frame_start_d = 1'b1;
         if (hold_valid_q) begin
            frame_word_d = hold_word_q;
            hold_valid_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
      end

      if (fall_tick) begin
         bit_cnt_d = bit_next;
         lrclk_d   = bit_next[5];
         sdata_d   = slot_word[slot_sel];
      end
   end

   always_ff @(posedge system_clock or posedge rst) begin
      if (rst) begin
         div_cnt_q     <= '0;
         bclk_q        <= 1'b0;
         bit_cnt_q     <= CNT_W'(63);
         lrclk_q       <= 1'b0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         hold_valid_q  <= 1'b0;
         hold_word_q   <= '0;
         frame_word_q  <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         bclk_q        <= bclk_d;
         bit_cnt_q     <= bit_cnt_d;
         lrclk_q       <= lrclk_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         hold_valid_q  <= hold_valid_d;
         hold_word_q   <= hold_word_d;
         frame_word_q  <= frame_word_d;
      end
   end

   assign sample_ready = !hold_valid_q;
   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign frame_start  = frame_start_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: a frame scoreboard on the default divider plus a
// directed check of a second instance with BCLK_DIV=2.
module tb_i2s_transmitter;

   localparam int unsigned SW = 24;

   typedef struct {
      logic [SW-1:0] word;
      logic          urun;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] sample_in;
   logic          sample_valid;
   logic          sample_ready, bclk, lrclk, sdata, frame_start, underrun;

   logic          rst2;
   logic [SW-1:0] sample_in2;
   logic          sample_valid2;
   logic          sample_ready2, bclk2, lrclk2, sdata2, frame_start2, underrun2;

   always #5 clk = ~clk;

   i2s_transmitter #(.SAMPLE_WIDTH(SW), .BCLK_DIV(8)) u_dut (
      .system_clock(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
      .frame_start(frame_start), .underrun(underrun)
   );

   i2s_transmitter #(.SAMPLE_WIDTH(SW), .BCLK_DIV(2)) u_dut2 (
      .system_clock(clk), .rst(rst2), .sample_in(sample_in2), .sample_valid(sample_valid2),
      .sample_ready(sample_ready2), .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2),
      .frame_start(frame_start2), .underrun(underrun2)
   );

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   frames_checked = 0;
   bit   done = 1'b0;
   bit   dut2_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   // Expected 64 bits as a receiver sees them on rising bclk, first bit in the MSB.
   function automatic logic [63:0] pat(input logic [SW-1:0] w);
      logic [31:0] s;
      s = {1'b0, w, 7'b0};
      return {s, s};
   endfunction

   task automatic push(input logic [SW-1:0] w, input logic u);
      exp_t e;
      e.word = w;
      e.urun = u;
      exp_q.push_back(e);
   endtask

   task automatic wait_fs(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 2000);
      if (!frame_start) fail_timeout(name);
   endtask

   task automatic send(input logic [SW-1:0] w);
      int n = 0;
      sample_valid = 1'b1;
      sample_in    = w;
      while (!sample_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!sample_ready) fail_timeout("send_ready");
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // Scoreboard monitor: one expected entry per frame_start, checked after 64 bits.
   int          cyc = 0;
   int          last_fs = 0;
   int          pos = 0;
   bit          have_last = 1'b0;
   bit          active = 1'b0;
   bit          prev_bclk = 1'b0;
   logic [63:0] sd_sh = '0;
   logic [63:0] lr_sh = '0;
   exp_t        cur;

   always @(negedge clk) begin
      cyc++;
      if (rst || done) begin
         active    = 1'b0;
         have_last = 1'b0;
         prev_bclk = 1'b0;
      end else begin
         if (frame_start) begin
            if (have_last) check("fs_interval", 64'(cyc - last_fs), 64'd1024);
            have_last = 1'b1;
            last_fs   = cyc;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_frame: got frame_start, expected no frame");
            end else begin
               cur    = exp_q.pop_front();
               active = 1'b1;
               pos    = 0;
               check("frame_underrun", 64'(underrun), 64'(cur.urun));
            end
         end
         if (bclk && !prev_bclk && active) begin
            sd_sh = {sd_sh[62:0], sdata};
            lr_sh = {lr_sh[62:0], lrclk};
            pos++;
            if (pos == 64) begin
               check("frame_sdata", sd_sh, pat(cur.word));
               check("frame_lrclk", lr_sh, 64'h00000000_FFFFFFFF);
               active = 1'b0;
               frames_checked++;
            end
         end
         prev_bclk = bclk;
      end
   end

   // Main stimulus on the default-divider instance.
   initial begin
      int k;
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      repeat (3) @(negedge clk);
      check("rst_bclk", 64'(bclk), 64'd0);
      check("rst_lrclk", 64'(lrclk), 64'd0);
      check("rst_sdata", 64'(sdata), 64'd0);
      check("rst_frame_start", 64'(frame_start), 64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_ready", 64'(sample_ready), 64'd1);

      push(24'hABCDEF, 1'b0);
      @(negedge clk);
      rst          = 1'b0;
      sample_valid = 1'b1;
      sample_in    = 24'hABCDEF;
      @(negedge clk);
      sample_valid = 1'b0;
      check("accept_one_cycle", 64'(sample_ready), 64'd0);
      k = 1;
      while (!frame_start && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("first_fs_cycle", 64'(k), 64'd16);

      // Backpressure: second sample waits until the next load empties the holder.
      push(24'h111111, 1'b0);
      send(24'h111111);
      push(24'h222222, 1'b0);
      sample_valid = 1'b1;
      sample_in    = 24'h222222;
      @(negedge clk);
      check("backpressure_ready", 64'(sample_ready), 64'd0);
      wait_fs("fs_f1");
      check("ready_after_load", 64'(sample_ready), 64'd1);
      @(negedge clk);
      sample_valid = 1'b0;
      check("accepted_after_load", 64'(sample_ready), 64'd0);

      wait_fs("fs_f2");
      push(24'h123456, 1'b0);
      send(24'h123456);
      wait_fs("fs_f3");
      push(24'h123456, 1'b1);
      wait_fs("fs_f4");
      check("underrun_set", 64'(underrun), 64'd1);
      push(24'h654321, 1'b1);
      send(24'h654321);
      wait_fs("fs_f5");
      check("underrun_sticky", 64'(underrun), 64'd1);

      // Mid-frame reset with a full holding register.
      repeat (300) @(negedge clk);
      send(24'hDEAD00);
      check("holder_full", 64'(sample_ready), 64'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_bclk", 64'(bclk), 64'd0);
      check("mid_rst_lrclk", 64'(lrclk), 64'd0);
      check("mid_rst_sdata", 64'(sdata), 64'd0);
      check("mid_rst_underrun", 64'(underrun), 64'd0);
      check("mid_rst_ready", 64'(sample_ready), 64'd1);

      // Collision: valid arrives exactly on the first load after reset.
      push(24'h000000, 1'b1);
      push(24'h0F0F0F, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check("no_early_fs", 64'(frame_start), 64'd0);
      sample_valid = 1'b1;
      sample_in    = 24'h0F0F0F;
      @(negedge clk);
      sample_valid = 1'b0;
      check("collision_fs_cycle16", 64'(frame_start), 64'd1);
      check("collision_underrun", 64'(underrun), 64'd1);
      check("collision_accepted", 64'(sample_ready), 64'd0);

      k = 0;
      while (frames_checked < 7 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("frames_completed", 64'(frames_checked), 64'd7);
      done = 1'b1;

      k = 0;
      while (!dut2_done && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (!dut2_done) fail_timeout("dut2_done");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // BCLK_DIV=2 instance: timing and bit layout with MSB and LSB set.
   initial begin
      int          k;
      int          c;
      int          nbits;
      int          rise0;
      int          rise1;
      int          fs0;
      bit          prev;
      logic [63:0] sd2;
      logic [63:0] lr2;
      rst2          = 1'b1;
      sample_valid2 = 1'b0;
      sample_in2    = '0;
      sd2           = '0;
      lr2           = '0;
      rise0         = 0;
      rise1         = 0;
      repeat (4) @(negedge clk);
      rst2          = 1'b0;
      sample_valid2 = 1'b1;
      sample_in2    = 24'h800001;
      @(negedge clk);
      sample_valid2 = 1'b0;
      k = 1;
      while (!frame_start2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("div2_first_fs", 64'(k), 64'd4);
      check("div2_underrun_clear", 64'(underrun2), 64'd0);

      c     = 0;
      fs0   = 0;
      nbits = 0;
      prev  = bclk2;
      while (nbits < 64 && c < 1000) begin
         @(negedge clk);
         c++;
         if (bclk2 && !prev) begin
            sd2 = {sd2[62:0], sdata2};
            lr2 = {lr2[62:0], lrclk2};
            if (nbits == 0) rise0 = c;
            if (nbits == 1) rise1 = c;
            nbits++;
         end
         prev = bclk2;
      end
      check("div2_bclk_period", 64'(rise1 - rise0), 64'd4);
      check("div2_sdata", sd2, pat(24'h800001));
      check("div2_lrclk", lr2, 64'h00000000_FFFFFFFF);

      while (!frame_start2 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      if (!frame_start2) fail_timeout("div2_second_fs");
      check("div2_fs_interval", 64'(c - fs0), 64'd256);
      check("div2_underrun", 64'(underrun2), 64'd1);
      dut2_done = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
